// File: rtl/instr_intake_unit_pkg.sv
// Shared types and constants for the instruction intake unit and the decode stage.
package instr_intake_unit_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefPcW   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StIssue,
    StDone
  } state_e;

  // Opcode/funct fields as used by the processor decode stage.
  localparam logic [5:0] OpRtype   = 6'h00;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] FunctAddu = 6'h21;
  localparam logic [5:0] FunctSubu = 6'h23;

endpackage

// File: rtl/instr_buffer_ram.sv
// Instruction buffer: one synchronous write port, one combinational read port,
// synchronously cleared on reset.
module instr_buffer_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PC_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PC_W-1:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 1 << PC_W;

  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_intake_unit.sv
// Receives a block of instructions from the loader into a small buffer, then
// issues the buffered words in address order to the execute stage.
module instr_intake_unit
  import instr_intake_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned PC_W   = DefPcW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instruct,
  input  logic              instruct_sig,
  input  logic [PC_W-1:0]   PC_initial,
  input  logic [PC_W-1:0]   MAX_PC,
  output logic              output_sig,
  output logic [PC_W-1:0]   PC_final,
  output logic              instruct_over,
  output logic              issue_valid,
  output logic [DATA_W-1:0] issue_instr,
  output logic [PC_W-1:0]   issue_pc,
  input  logic              issue_ready
);

  localparam logic [PC_W-1:0] PcOne = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PC_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0] max_q, max_d;
  logic            rdy_q, rdy_d;

  logic              buf_we;
  logic [PC_W-1:0]   buf_waddr;
  logic [DATA_W-1:0] buf_rdata;

  instr_buffer_ram #(
    .DATA_W(DATA_W),
    .PC_W  (PC_W)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (buf_we),
    .waddr(buf_waddr),
    .wdata(instruct),
    .raddr(rd_ptr_q),
    .rdata(buf_rdata)
  );

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    max_d     = max_q;
    buf_we    = 1'b0;
    buf_waddr = wr_ptr_q;

    unique case (state_q)
      StIdle: begin
        // PC_initial/MAX_PC are only honoured on this first strobe.
        if (instruct_sig) begin
          buf_we    = 1'b1;
          buf_waddr = PC_initial;
          max_d     = MAX_PC;
          if (PC_initial >= MAX_PC) begin
            state_d  = StIssue;
            rd_ptr_d = '0;
          end else begin
            wr_ptr_d = PC_initial + PcOne;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        if (instruct_sig) begin
          buf_we = 1'b1;
          if (wr_ptr_q == max_q) begin
            state_d  = StIssue;
            rd_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + PcOne;
          end
        end
      end
      StIssue: begin
        if (issue_ready) begin
          if (rd_ptr_q == max_q) begin
            state_d = StDone;
          end else begin
            rd_ptr_d = rd_ptr_q + PcOne;
          end
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase

    rdy_d = (state_d == StIdle) || (state_d == StLoad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      max_q    <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      max_q    <= max_d;
      rdy_q    <= rdy_d;
    end
  end

  assign output_sig    = rdy_q;
  assign PC_final      = wr_ptr_q;
  assign instruct_over = (state_q == StIssue) || (state_q == StDone);
  assign issue_valid   = (state_q == StIssue);
  assign issue_instr   = issue_valid ? buf_rdata : '0;
  assign issue_pc      = issue_valid ? rd_ptr_q : '0;

endmodule

// File: tb/tb_instr_intake_unit.sv
// Directed and randomized checks of instr_intake_unit against an array model of the buffer.
module tb_instr_intake_unit;
  import instr_intake_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruct = '0;
  logic        instruct_sig = 1'b0;
  logic [2:0]  PC_initial = '0;
  logic [2:0]  MAX_PC = '0;
  logic        output_sig;
  logic [2:0]  PC_final;
  logic        instruct_over;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [2:0]  issue_pc;
  logic        issue_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [8];
  logic [31:0] words [8];

  instr_intake_unit #(
    .DATA_W(32),
    .PC_W  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instruct     (instruct),
    .instruct_sig (instruct_sig),
    .PC_initial   (PC_initial),
    .MAX_PC       (MAX_PC),
    .output_sig   (output_sig),
    .PC_final     (PC_final),
    .instruct_over(instruct_over),
    .issue_valid  (issue_valid),
    .issue_instr  (issue_instr),
    .issue_pc     (issue_pc),
    .issue_ready  (issue_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    if ($urandom_range(0, 1) == 0) begin
      w = {OpRtype, 5'($urandom), 5'($urandom), 5'($urandom), 5'b0, FunctAddu};
    end else begin
      w = {OpBne, 5'($urandom), 5'($urandom), 16'($urandom)};
    end
    return w;
  endfunction

  function automatic int entries(input int init, input int max);
    return (init >= max) ? 1 : max - init + 1;
  endfunction

  task automatic do_reset(input logic strobe);
    rst = 1'b1;
    instruct_sig = strobe;
    instruct = rand_word();
    PC_initial = 3'd0;
    MAX_PC = 3'd0;
    tick();
    rst = 1'b0;
    instruct_sig = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    chk("rst output_sig", 32'(output_sig), 32'd0);
    chk("rst PC_final", 32'(PC_final), 32'd0);
    chk("rst instruct_over", 32'(instruct_over), 32'd0);
    chk("rst issue_valid", 32'(issue_valid), 32'd0);
    chk("rst issue_instr", issue_instr, 32'd0);
    chk("rst issue_pc", 32'(issue_pc), 32'd0);
    tick();
    chk("idle output_sig", 32'(output_sig), 32'd1);
    chk("idle instruct_over", 32'(instruct_over), 32'd0);
  endtask

  // Send nsend words starting at init; PC_initial/MAX_PC are scrambled after the first.
  task automatic load(input int init, input int max, input int nsend, input int gap);
    int n;
    n = entries(init, max);
    for (int k = 0; k < nsend; k++) begin
      instruct = words[k];
      instruct_sig = 1'b1;
      if (k == 0) begin
        PC_initial = 3'(init);
        MAX_PC = 3'(max);
      end else begin
        PC_initial = 3'($urandom);
        MAX_PC = 3'($urandom);
      end
      tick();
      instruct_sig = 1'b0;
      PC_initial = 3'($urandom);
      MAX_PC = 3'($urandom);
      ref_mem[init + k] = words[k];
      if (k == n - 1) begin
        chk("load end instruct_over", 32'(instruct_over), 32'd1);
        chk("load end issue_valid", 32'(issue_valid), 32'd1);
        chk("load end output_sig", 32'(output_sig), 32'd0);
      end else begin
        chk($sformatf("load PC_final k%0d", k), 32'(PC_final), 32'(init + k + 1));
        chk("load output_sig", 32'(output_sig), 32'd1);
        chk("load instruct_over", 32'(instruct_over), 32'd0);
        for (int g = 0; g < gap; g++) begin
          instruct = rand_word();
          tick();
          chk("gap PC_final", 32'(PC_final), 32'(init + k + 1));
        end
      end
    end
  endtask

  // Expect pcs 0..max in order; optionally stall at stall_pc while strobing junk.
  task automatic drain(input int max, input int stall_pc, input int stall_len);
    for (int pc = 0; pc <= max; pc++) begin
      chk($sformatf("issue_valid pc%0d", pc), 32'(issue_valid), 32'd1);
      chk($sformatf("issue_pc pc%0d", pc), 32'(issue_pc), 32'(pc));
      chk($sformatf("issue_instr pc%0d", pc), issue_instr, ref_mem[pc]);
      if (pc == stall_pc) begin
        issue_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          instruct_sig = 1'b1;
          instruct = rand_word();
          tick();
          chk("stall issue_valid", 32'(issue_valid), 32'd1);
          chk("stall issue_pc", 32'(issue_pc), 32'(pc));
          chk("stall issue_instr", issue_instr, ref_mem[pc]);
        end
        instruct_sig = 1'b0;
        issue_ready = 1'b1;
      end
      tick();
    end
    chk("done issue_valid", 32'(issue_valid), 32'd0);
    chk("done instruct_over", 32'(instruct_over), 32'd1);
    chk("done output_sig", 32'(output_sig), 32'd0);
    instruct_sig = 1'b1;
    tick();
    instruct_sig = 1'b0;
    chk("done hold issue_valid", 32'(issue_valid), 32'd0);
    chk("done hold instruct_over", 32'(instruct_over), 32'd1);
  endtask

  task automatic std_words();
    words[0] = 32'h1401002D;
    words[1] = 32'h1402FFEC;
    words[2] = 32'h1403FFC4;
    words[3] = 32'h00222821;
    words[4] = 32'h00643021;
    words[5] = 32'h00A62823;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 8; i++) words[i] = rand_word();
  endtask

  initial begin
    // Standard load
    do_reset(1'b0);
    std_words();
    load(0, 5, 6, 0);
    drain(5, -1, 0);

    // Gapped strobes, with a strobe dropped under reset
    do_reset(1'b1);
    std_words();
    load(0, 5, 6, 3);
    drain(5, -1, 0);

    // Offset start
    do_reset(1'b0);
    words[0] = 32'hAAAA0001;
    words[1] = 32'hAAAA0002;
    words[2] = 32'hAAAA0003;
    load(2, 4, 3, 0);
    drain(4, -1, 0);

    // Single entry, and PC_initial above MAX_PC
    do_reset(1'b0);
    words[0] = 32'h12345678;
    load(3, 3, 1, 0);
    drain(3, -1, 0);
    do_reset(1'b0);
    rand_words();
    load(6, 2, 1, 0);
    drain(2, -1, 0);

    // Backpressure at pc2 with strobes during issue
    do_reset(1'b0);
    rand_words();
    load(0, 5, 6, 0);
    drain(5, 2, 4);

    // Reset mid-load, then partial load must see cleared entries
    do_reset(1'b0);
    std_words();
    load(0, 5, 3, 0);
    do_reset(1'b0);
    rand_words();
    load(3, 5, 3, 0);
    drain(5, -1, 0);
    do_reset(1'b0);
    std_words();
    load(0, 5, 6, 0);
    drain(5, -1, 0);

    // Full buffer
    do_reset(1'b0);
    rand_words();
    load(0, 7, 8, 1);
    drain(7, 7, 2);

    // Randomized trials
    for (int t = 0; t < 6; t++) begin
      int init, max;
      init = int'($urandom_range(0, 7));
      max = int'($urandom_range(0, 7));
      do_reset(1'($urandom_range(0, 1)));
      rand_words();
      load(init, max, entries(init, max), int'($urandom_range(0, 2)));
      drain(max, int'($urandom_range(0, max)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
